exc_ctrl: RTL and testbench

- Exception controller that sequences the fetch stage's exception redirect path.
- Decides when fetch must leave normal PC flow (PC+4 / branch) and drive the exception vector or the return address.
- Owns the exception link register (ELR), the syndrome register (ESR) and the handler-mode state.
- Sits beside fetch; drives fetch's EProc_F / EVAddr_F inputs; consumes decode's illegal/ERET flags.

---
 rtl/exc_pkg.sv | 16 +
 rtl/flopre.sv | 18 +
 rtl/exc_ctrl.sv | 126 ++++++++++++
 tb/tb_exc_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared state and syndrome definitions for the exception controller
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } exc_state_e;

  localparam logic [3:0] ESR_NONE     = 4'h0;
  localparam logic [3:0] ESR_ILLEGAL  = 4'h1;
  localparam logic [3:0] ESR_IRQ      = 4'h2;
  localparam logic [3:0] ESR_ERET_RUN = 4'h3;
  localparam logic [3:0] ESR_DFAULT   = 4'hF;

endpackage

// File: rtl/flopre.sv
// rtl/flopre.sv - N-wide register with synchronous active-high reset and load enable
module flopre #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Reset clears, enable loads, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - fetch exception redirect sequencer (interrupt path enabled by EXC_IRQ_EN)
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int          N        = 64,
  parameter logic [63:0] VEC_BASE = 64'hD8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         exc_illegal_i,
  input  logic         eret_i,
  input  logic         irq_i,
  input  logic [N-1:0] imem_addr_F,
  input  logic [N-1:0] NextPC_F,
  output logic         EProc_F,
  output logic [N-1:0] EVAddr_F,
  output logic [N-1:0] elr_o,
  output logic [3:0]   esr_o,
  output logic         in_handler_o
);

  exc_state_e   state_q, state_d;
  logic         irq_pend_q;
  logic         irq_take;
  logic         elr_en, esr_en;
  logic [N-1:0] elr_d;
  logic [3:0]   esr_d;

`ifdef EXC_IRQ_EN
  logic irq_pend_d;

  // A new pulse wins over the clear from taking the previous request.
  always_comb begin
    irq_pend_d = irq_i | (irq_pend_q & ~irq_take);
  end

  // Pending interrupt flag; repeated pulses collapse into one request.
  always_ff @(posedge clk) begin
    if (reset) irq_pend_q <= 1'b0;
    else       irq_pend_q <= irq_pend_d;
  end
`else
  logic irq_unused;
  assign irq_unused = irq_i | irq_take;
  assign irq_pend_q = 1'b0;
`endif

  // Handler-mode state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state, redirect outputs and ELR/ESR load controls.
  always_comb begin
    state_d  = state_q;
    EProc_F  = 1'b0;
    EVAddr_F = '0;
    elr_en   = 1'b0;
    elr_d    = imem_addr_F;
    esr_en   = 1'b0;
    esr_d    = ESR_NONE;
    irq_take = 1'b0;
    unique case (state_q)
      RUN: begin
        if (exc_illegal_i || eret_i || irq_pend_q) begin
          EProc_F  = 1'b1;
          EVAddr_F = VEC_BASE[N-1:0];
          elr_en   = 1'b1;
          esr_en   = 1'b1;
          state_d  = HANDLER;
          if (exc_illegal_i) begin
            esr_d = ESR_ILLEGAL;
          end else if (eret_i) begin
            esr_d = ESR_ERET_RUN;
          end else begin
            // Interrupts resume at the instruction fetch would have taken next.
            elr_d    = NextPC_F;
            esr_d    = ESR_IRQ;
            irq_take = 1'b1;
          end
        end
      end
      HANDLER: begin
        if (exc_illegal_i) begin
          // Double fault: freeze the PC where it faulted.
          EProc_F  = 1'b1;
          EVAddr_F = imem_addr_F;
          esr_en   = 1'b1;
          esr_d    = ESR_DFAULT;
          state_d  = HALT;
        end else if (eret_i) begin
          EProc_F  = 1'b1;
          EVAddr_F = elr_o;
          state_d  = RUN;
        end
      end
      HALT: begin
        EProc_F  = 1'b1;
        EVAddr_F = imem_addr_F;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  flopre #(.N(N)) u_elr (
    .clk   (clk),
    .reset (reset),
    .en    (elr_en),
    .d     (elr_d),
    .q     (elr_o)
  );

  flopre #(.N(4)) u_esr (
    .clk   (clk),
    .reset (reset),
    .en    (esr_en),
    .d     (esr_d),
    .q     (esr_o)
  );

  assign in_handler_o = (state_q == HANDLER);

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl (irq checks depend on EXC_IRQ_EN)
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_illegal_i, eret_i, irq_i;
  logic [63:0] imem_addr_F, NextPC_F;
  logic        EProc_F;
  logic [63:0] EVAddr_F, elr_o;
  logic [3:0]  esr_o;
  logic        in_handler_o;

  int errors = 0;
  int checks = 0;

  exc_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .exc_illegal_i (exc_illegal_i),
    .eret_i        (eret_i),
    .irq_i         (irq_i),
    .imem_addr_F   (imem_addr_F),
    .NextPC_F      (NextPC_F),
    .EProc_F       (EProc_F),
    .EVAddr_F      (EVAddr_F),
    .elr_o         (elr_o),
    .esr_o         (esr_o),
    .in_handler_o  (in_handler_o)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs return to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    exc_illegal_i = 1'b0;
    eret_i        = 1'b0;
    irq_i         = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; exc_illegal_i = 1'b1; eret_i = 1'b0; irq_i = 1'b1;
    imem_addr_F = 64'h10; NextPC_F = 64'h14;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exc_illegal_i = 1'b0; irq_i = 1'b0; #1;
    checks++; if (EProc_F !== 1'b0) begin errors++; $display("FAIL rst_eproc got=%0h exp=0", EProc_F); end
    checks++; if (EVAddr_F !== 64'h0) begin errors++; $display("FAIL rst_evaddr got=%0h exp=0", EVAddr_F); end
    checks++; if (elr_o !== 64'h0) begin errors++; $display("FAIL rst_elr got=%0h exp=0", elr_o); end
    checks++; if (esr_o !== 4'h0) begin errors++; $display("FAIL rst_esr got=%0h exp=0", esr_o); end
    checks++; if (in_handler_o !== 1'b0) begin errors++; $display("FAIL rst_inh got=%0h exp=0", in_handler_o); end
    reset = 1'b0;
    tick();
    // An irq pulse during reset must not leave a pending request behind.
    checks++; if (EProc_F !== 1'b0) begin errors++; $display("FAIL rst_no_pend got=%0h exp=0", EProc_F); end
  endtask

  task automatic test_illegal_entry();
    imem_addr_F = 64'h40; NextPC_F = 64'h44; exc_illegal_i = 1'b1; #1;
    checks++; if (EProc_F !== 1'b1) begin errors++; $display("FAIL ill_eproc got=%0h exp=1", EProc_F); end
    checks++; if (EVAddr_F !== 64'hD8) begin errors++; $display("FAIL ill_evaddr got=%0h exp=d8", EVAddr_F); end
    tick();
    checks++; if (elr_o !== 64'h40) begin errors++; $display("FAIL ill_elr got=%0h exp=40", elr_o); end
    checks++; if (esr_o !== 4'h1) begin errors++; $display("FAIL ill_esr got=%0h exp=1", esr_o); end
    checks++; if (in_handler_o !== 1'b1) begin errors++; $display("FAIL ill_inh got=%0h exp=1", in_handler_o); end
    checks++; if ({EProc_F, EVAddr_F} !== {1'b0, 64'h0}) begin errors++; $display("FAIL hnd_idle got=%0h/%0h exp=0/0", EProc_F, EVAddr_F); end
  endtask

  task automatic test_eret_return();
    imem_addr_F = 64'hE4; eret_i = 1'b1; #1;
    checks++; if (EProc_F !== 1'b1) begin errors++; $display("FAIL eret_eproc got=%0h exp=1", EProc_F); end
    checks++; if (EVAddr_F !== 64'h40) begin errors++; $display("FAIL eret_evaddr got=%0h exp=40", EVAddr_F); end
    tick();
    checks++; if (in_handler_o !== 1'b0) begin errors++; $display("FAIL eret_inh got=%0h exp=0", in_handler_o); end
    checks++; if (esr_o !== 4'h1) begin errors++; $display("FAIL eret_esr_hold got=%0h exp=1", esr_o); end
    checks++; if (EProc_F !== 1'b0) begin errors++; $display("FAIL eret_run_idle got=%0h exp=0", EProc_F); end
  endtask

  task automatic test_eret_in_run();
    imem_addr_F = 64'h60; NextPC_F = 64'h64; eret_i = 1'b1; #1;
    checks++; if (EVAddr_F !== 64'hD8) begin errors++; $display("FAIL eretrun_evaddr got=%0h exp=d8", EVAddr_F); end
    tick();
    checks++; if (elr_o !== 64'h60) begin errors++; $display("FAIL eretrun_elr got=%0h exp=60", elr_o); end
    checks++; if (esr_o !== 4'h3) begin errors++; $display("FAIL eretrun_esr got=%0h exp=3", esr_o); end
    checks++; if (in_handler_o !== 1'b1) begin errors++; $display("FAIL eretrun_inh got=%0h exp=1", in_handler_o); end
    eret_i = 1'b1; #1;
    checks++; if (EVAddr_F !== 64'h60) begin errors++; $display("FAIL eretrun_ret got=%0h exp=60", EVAddr_F); end
    tick();
  endtask

  task automatic test_irq();
    imem_addr_F = 64'h80; NextPC_F = 64'h84; irq_i = 1'b1; #1;
    checks++; if (EProc_F !== 1'b0) begin errors++; $display("FAIL irq_same_cycle got=%0h exp=0", EProc_F); end
    tick();
`ifdef EXC_IRQ_EN
    checks++; if ({EProc_F, EVAddr_F} !== {1'b1, 64'hD8}) begin errors++; $display("FAIL irq_take got=%0h/%0h exp=1/d8", EProc_F, EVAddr_F); end
    tick();
    checks++; if (elr_o !== 64'h84) begin errors++; $display("FAIL irq_elr got=%0h exp=84", elr_o); end
    checks++; if (esr_o !== 4'h2) begin errors++; $display("FAIL irq_esr got=%0h exp=2", esr_o); end
    // Pulse inside the handler is held until the first RUN cycle.
    irq_i = 1'b1; #1;
    checks++; if (EProc_F !== 1'b0) begin errors++; $display("FAIL irq_hnd_ignored got=%0h exp=0", EProc_F); end
    tick();
    checks++; if (EProc_F !== 1'b0) begin errors++; $display("FAIL irq_hnd_held got=%0h exp=0", EProc_F); end
    eret_i = 1'b1; #1;
    checks++; if (EVAddr_F !== 64'h84) begin errors++; $display("FAIL irq_eret got=%0h exp=84", EVAddr_F); end
    tick();
    NextPC_F = 64'h90; #1;
    checks++; if ({EProc_F, EVAddr_F} !== {1'b1, 64'hD8}) begin errors++; $display("FAIL irq_after_eret got=%0h/%0h exp=1/d8", EProc_F, EVAddr_F); end
    tick();
    checks++; if ({elr_o, esr_o} !== {64'h90, 4'h2}) begin errors++; $display("FAIL irq_after_eret_regs got=%0h/%0h exp=90/2", elr_o, esr_o); end
    eret_i = 1'b1; tick();
    // Illegal beats a pending irq, which survives the handler.
    irq_i = 1'b1; tick();
    imem_addr_F = 64'h44; NextPC_F = 64'h48; exc_illegal_i = 1'b1; #1;
    checks++; if (EVAddr_F !== 64'hD8) begin errors++; $display("FAIL prio_evaddr got=%0h exp=d8", EVAddr_F); end
    tick();
    checks++; if ({elr_o, esr_o} !== {64'h44, 4'h1}) begin errors++; $display("FAIL prio_regs got=%0h/%0h exp=44/1", elr_o, esr_o); end
    eret_i = 1'b1; tick();
    checks++; if (EProc_F !== 1'b1) begin errors++; $display("FAIL prio_pend_kept got=%0h exp=1", EProc_F); end
    tick();
    checks++; if ({elr_o, esr_o} !== {64'h48, 4'h2}) begin errors++; $display("FAIL prio_irq_regs got=%0h/%0h exp=48/2", elr_o, esr_o); end
    eret_i = 1'b1; tick();
    checks++; if ({EProc_F, in_handler_o} !== 2'b00) begin errors++; $display("FAIL irq_cleared got=%0b exp=00", {EProc_F, in_handler_o}); end
`else
    checks++; if (EProc_F !== 1'b0) begin errors++; $display("FAIL irq_off_eproc got=%0h exp=0", EProc_F); end
    tick();
    checks++; if ({in_handler_o, esr_o} !== {1'b0, 4'h3}) begin errors++; $display("FAIL irq_off_state got=%0h/%0h exp=0/3", in_handler_o, esr_o); end
`endif
  endtask

  task automatic test_double_fault();
    imem_addr_F = 64'h50; exc_illegal_i = 1'b1; tick();
    imem_addr_F = 64'hE0; exc_illegal_i = 1'b1; #1;
    checks++; if ({EProc_F, EVAddr_F} !== {1'b1, 64'hE0}) begin errors++; $display("FAIL df_redirect got=%0h/%0h exp=1/e0", EProc_F, EVAddr_F); end
    tick();
    checks++; if ({esr_o, elr_o} !== {4'hF, 64'h50}) begin errors++; $display("FAIL df_regs got=%0h/%0h exp=f/50", esr_o, elr_o); end
    checks++; if (in_handler_o !== 1'b0) begin errors++; $display("FAIL df_inh got=%0h exp=0", in_handler_o); end
    for (int i = 0; i < 3; i++) begin
      eret_i = 1'b1; #1;
      checks++; if ({EProc_F, EVAddr_F} !== {1'b1, 64'hE0}) begin errors++; $display("FAIL df_halt_%0d got=%0h/%0h exp=1/e0", i, EProc_F, EVAddr_F); end
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0; #1;
    checks++; if ({EProc_F, esr_o, elr_o} !== {1'b0, 4'h0, 64'h0}) begin errors++; $display("FAIL df_reset got=%0h/%0h/%0h exp=0/0/0", EProc_F, esr_o, elr_o); end
  endtask

  task automatic test_reset_mid_handler();
    imem_addr_F = 64'h70; exc_illegal_i = 1'b1; tick();
    reset = 1'b1; eret_i = 1'b1; tick(); tick(); reset = 1'b0; #1;
    checks++; if ({in_handler_o, EProc_F, EVAddr_F} !== {2'b00, 64'h0}) begin errors++; $display("FAIL rstmid_state got=%0h/%0h/%0h exp=0/0/0", in_handler_o, EProc_F, EVAddr_F); end
    checks++; if ({elr_o, esr_o} !== {64'h0, 4'h0}) begin errors++; $display("FAIL rstmid_regs got=%0h/%0h exp=0/0", elr_o, esr_o); end
  endtask

  initial begin
    test_reset();
    test_illegal_entry();
    test_eret_return();
    test_eret_in_run();
    test_irq();
    test_double_fault();
    test_reset_mid_handler();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
